l2_cache_lookup_stage: RTL and testbench

// Consumer end of the L2 tag-stage interface. Takes per-way tag/valid/dirty + LRU fill way from the tag stage,

---
 rtl/l2_cache_lookup_stage_if.sv | 81 ++++++++
 rtl/l2_cache_lookup_stage.sv | 160 ++++++++++++++++
 tb/tb_l2_cache_lookup_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_lookup_stage_if.sv
// Bundle between the L2 tag stage, the lookup stage and the update stage.
// The master side is the surrounding pipeline; the slave side is the lookup stage.
interface l2_cache_lookup_stage_if #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 256,
  parameter int TAG_W    = 16,
  parameter int LINE_W   = 512
);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int ADDR_W = WAY_W + SET_W;

  // Request and per-way metadata from the tag stage
  logic                l2t_request_valid;
  logic [1:0]          l2t_request_op;
  logic [TAG_W-1:0]    l2t_request_tag;
  logic [SET_W-1:0]    l2t_request_set;
  logic [NUM_WAYS-1:0] l2t_valid;
  logic [TAG_W-1:0]    l2t_tag [NUM_WAYS];
  logic [NUM_WAYS-1:0] l2t_dirty;
  logic                l2t_is_l2_fill;
  logic [WAY_W-1:0]    l2t_fill_way;
  logic [LINE_W-1:0]   l2t_data_from_memory;
  logic                l2t_is_restarted_flush;

  // Metadata update ports back to the tag stage
  logic [NUM_WAYS-1:0] l2r_update_tag_en;
  logic [SET_W-1:0]    l2r_update_tag_set;
  logic                l2r_update_tag_valid;
  logic [TAG_W-1:0]    l2r_update_tag_value;
  logic [NUM_WAYS-1:0] l2r_update_dirty_en;
  logic [SET_W-1:0]    l2r_update_dirty_set;
  logic                l2r_update_dirty_value;
  logic                l2r_update_lru_en;
  logic [WAY_W-1:0]    l2r_update_lru_hit_way;

  // Data SRAM write from the update stage
  logic                l2u_write_en;
  logic [ADDR_W-1:0]   l2u_write_addr;
  logic [LINE_W-1:0]   l2u_write_data;

  // Registered result to the update stage
  logic                l2r_request_valid;
  logic [1:0]          l2r_request_op;
  logic [TAG_W-1:0]    l2r_request_tag;
  logic [SET_W-1:0]    l2r_request_set;
  logic                l2r_cache_hit;
  logic [WAY_W-1:0]    l2r_hit_way;
  logic                l2r_is_l2_fill;
  logic                l2r_is_restarted_flush;
  logic                l2r_needs_writeback;
  logic [TAG_W-1:0]    l2r_writeback_tag;
  logic [LINE_W-1:0]   l2r_data;
  logic [LINE_W-1:0]   l2r_data_from_memory;

  modport master (
    output l2t_request_valid, l2t_request_op, l2t_request_tag, l2t_request_set,
           l2t_valid, l2t_tag, l2t_dirty, l2t_is_l2_fill, l2t_fill_way,
           l2t_data_from_memory, l2t_is_restarted_flush,
           l2u_write_en, l2u_write_addr, l2u_write_data,
    input  l2r_update_tag_en, l2r_update_tag_set, l2r_update_tag_valid, l2r_update_tag_value,
           l2r_update_dirty_en, l2r_update_dirty_set, l2r_update_dirty_value,
           l2r_update_lru_en, l2r_update_lru_hit_way,
           l2r_request_valid, l2r_request_op, l2r_request_tag, l2r_request_set,
           l2r_cache_hit, l2r_hit_way, l2r_is_l2_fill, l2r_is_restarted_flush,
           l2r_needs_writeback, l2r_writeback_tag, l2r_data, l2r_data_from_memory
  );

  modport slave (
    input  l2t_request_valid, l2t_request_op, l2t_request_tag, l2t_request_set,
           l2t_valid, l2t_tag, l2t_dirty, l2t_is_l2_fill, l2t_fill_way,
           l2t_data_from_memory, l2t_is_restarted_flush,
           l2u_write_en, l2u_write_addr, l2u_write_data,
    output l2r_update_tag_en, l2r_update_tag_set, l2r_update_tag_valid, l2r_update_tag_value,
           l2r_update_dirty_en, l2r_update_dirty_set, l2r_update_dirty_value,
           l2r_update_lru_en, l2r_update_lru_hit_way,
           l2r_request_valid, l2r_request_op, l2r_request_tag, l2r_request_set,
           l2r_cache_hit, l2r_hit_way, l2r_is_l2_fill, l2r_is_restarted_flush,
           l2r_needs_writeback, l2r_writeback_tag, l2r_data, l2r_data_from_memory
  );
endinterface

// File: rtl/l2_cache_lookup_stage.sv
// L2 lookup stage: resolves hit/miss from tag-stage metadata, drives tag/dirty/LRU
// updates combinationally and reads the line SRAM into a one-cycle registered result.
module l2_cache_lookup_stage #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 256,
  parameter int TAG_W    = 16,
  parameter int LINE_W   = 512
) (
  input logic                    clk,
  input logic                    reset,
  l2_cache_lookup_stage_if.slave bus
);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int ADDR_W = WAY_W + SET_W;

  typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_FLUSH, OP_INVALIDATE} op_e;

  op_e                 op;
  logic                active;
  logic [NUM_WAYS-1:0] hit_oh;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                fill_miss;
  logic [WAY_W-1:0]    rd_way;
  logic [ADDR_W-1:0]   rd_addr;
  logic [LINE_W-1:0]   rd_data;

  logic [NUM_WAYS-1:0] tag_en, dirty_en;
  logic                tag_valid, dirty_value, lru_en, needs_wb;
  logic [TAG_W-1:0]    wb_tag;

  logic [LINE_W-1:0]   mem [NUM_WAYS*NUM_SETS];

  logic                req_valid_q, cache_hit_q, is_fill_q, restarted_q, needs_wb_q;
  logic [1:0]          op_q;
  logic [TAG_W-1:0]    tag_q, wb_tag_q;
  logic [SET_W-1:0]    set_q;
  logic [WAY_W-1:0]    hit_way_q;
  logic [LINE_W-1:0]   data_q, data_d, mem_data_q;

  assign op        = op_e'(bus.l2t_request_op);
  assign active    = bus.l2t_request_valid & reset;
  assign hit       = |hit_oh;
  assign fill_miss = bus.l2t_is_l2_fill & ~hit;

  always_comb begin
    hit_oh  = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      hit_oh[w] = bus.l2t_valid[w] & (bus.l2t_tag[w] == bus.l2t_request_tag);
      if (hit_oh[w]) hit_way = hit_way | WAY_W'(w);
    end
  end

  // A fill that already hits (duplicate miss) is handled as an ordinary hit.
  always_comb begin
    tag_en      = '0;
    tag_valid   = 1'b0;
    dirty_en    = '0;
    dirty_value = 1'b0;
    lru_en      = 1'b0;
    needs_wb    = 1'b0;
    rd_way      = fill_miss ? bus.l2t_fill_way : hit_way;
    wb_tag      = bus.l2t_tag[rd_way];
    if (active) begin
      if (fill_miss) begin
        tag_en      = NUM_WAYS'(1) << bus.l2t_fill_way;
        tag_valid   = 1'b1;
        dirty_en    = NUM_WAYS'(1) << bus.l2t_fill_way;
        dirty_value = (op == OP_STORE);
        lru_en      = 1'b1;
        needs_wb    = bus.l2t_valid[bus.l2t_fill_way] & bus.l2t_dirty[bus.l2t_fill_way];
      end else if (hit) begin
        unique case (op)
          OP_LOAD:  lru_en = 1'b1;
          OP_STORE: begin
            dirty_en    = hit_oh;
            dirty_value = 1'b1;
            lru_en      = 1'b1;
          end
          OP_FLUSH: begin
            dirty_en = hit_oh;
            needs_wb = bus.l2t_dirty[hit_way];
          end
          OP_INVALIDATE: begin
            tag_en   = hit_oh;
            dirty_en = hit_oh;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.l2r_update_tag_en      = tag_en;
  assign bus.l2r_update_tag_set     = bus.l2t_request_set;
  assign bus.l2r_update_tag_valid   = tag_valid;
  assign bus.l2r_update_tag_value   = bus.l2t_request_tag;
  assign bus.l2r_update_dirty_en    = dirty_en;
  assign bus.l2r_update_dirty_set   = bus.l2t_request_set;
  assign bus.l2r_update_dirty_value = dirty_value;
  assign bus.l2r_update_lru_en      = lru_en;
  assign bus.l2r_update_lru_hit_way = rd_way;

  // Write-first: a same-cycle update-stage write to the read address wins.
  assign rd_addr = {rd_way, bus.l2t_request_set};
  assign rd_data = mem[rd_addr];
  assign data_d  = (bus.l2u_write_en && bus.l2u_write_addr == rd_addr) ? bus.l2u_write_data : rd_data;

  always_ff @(posedge clk) begin
    if (bus.l2u_write_en) mem[bus.l2u_write_addr] <= bus.l2u_write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_valid_q <= 1'b0;
      cache_hit_q <= 1'b0;
      is_fill_q   <= 1'b0;
      restarted_q <= 1'b0;
      needs_wb_q  <= 1'b0;
      op_q        <= '0;
      tag_q       <= '0;
      set_q       <= '0;
      hit_way_q   <= '0;
      wb_tag_q    <= '0;
      data_q      <= '0;
      mem_data_q  <= '0;
    end else begin
      req_valid_q <= bus.l2t_request_valid;
      cache_hit_q <= bus.l2t_request_valid & hit;
      is_fill_q   <= bus.l2t_request_valid & bus.l2t_is_l2_fill;
      restarted_q <= bus.l2t_request_valid & bus.l2t_is_restarted_flush;
      needs_wb_q  <= needs_wb;
      op_q        <= bus.l2t_request_op;
      tag_q       <= bus.l2t_request_tag;
      set_q       <= bus.l2t_request_set;
      hit_way_q   <= rd_way;
      wb_tag_q    <= wb_tag;
      mem_data_q  <= bus.l2t_data_from_memory;
      if (bus.l2t_request_valid) data_q <= data_d;
    end
  end

  assign bus.l2r_request_valid      = req_valid_q;
  assign bus.l2r_request_op         = op_q;
  assign bus.l2r_request_tag        = tag_q;
  assign bus.l2r_request_set        = set_q;
  assign bus.l2r_cache_hit          = cache_hit_q;
  assign bus.l2r_hit_way            = hit_way_q;
  assign bus.l2r_is_l2_fill         = is_fill_q;
  assign bus.l2r_is_restarted_flush = restarted_q;
  assign bus.l2r_needs_writeback    = needs_wb_q;
  assign bus.l2r_writeback_tag      = wb_tag_q;
  assign bus.l2r_data               = data_q;
  assign bus.l2r_data_from_memory   = mem_data_q;

  a_single_hit: assert property (@(posedge clk) disable iff (!reset)
    bus.l2t_request_valid |-> $onehot0(hit_oh));
endmodule

// File: tb/tb_l2_cache_lookup_stage.sv
// Directed table vectors, hand sequences against an emulated tag store, and a
// random back-to-back run checked against a hit/writeback reference.
module tb_l2_cache_lookup_stage;
  localparam int NW = 8;
  localparam int NS = 256;
  localparam int TW = 16;
  localparam int LW = 64;
  localparam logic [1:0] LD = 2'd0, ST = 2'd1, FL = 2'd2, INV = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic use_store = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  l2_cache_lookup_stage_if #(.NUM_WAYS(NW), .NUM_SETS(NS), .TAG_W(TW), .LINE_W(LW)) bus ();

  l2_cache_lookup_stage #(.NUM_WAYS(NW), .NUM_SETS(NS), .TAG_W(TW), .LINE_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Emulated tag-stage metadata, updated from the DUT's strobes.
  logic          sv [8][8];
  logic [TW-1:0] stg [8][8];
  logic          sd [8][8];

  always @(posedge clk) begin
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 8; w++)
        if (!use_store) begin
          sv[s][w]  <= 1'b0;
          stg[s][w] <= '0;
          sd[s][w]  <= 1'b0;
        end else begin
          if (bus.l2r_update_tag_en[w] && bus.l2r_update_tag_set[2:0] == 3'(s)) begin
            sv[s][w]  <= bus.l2r_update_tag_valid;
            stg[s][w] <= bus.l2r_update_tag_value;
          end
          if (bus.l2r_update_dirty_en[w] && bus.l2r_update_dirty_set[2:0] == 3'(s))
            sd[s][w] <= bus.l2r_update_dirty_value;
        end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic req(input logic v, input logic [1:0] op, input logic fill, input logic [TW-1:0] tg,
                     input logic [7:0] st, input logic [2:0] fw, input logic [7:0] vm, input logic [7:0] dm);
    @(negedge clk);
    bus.l2t_request_valid    = v;
    bus.l2t_request_op       = op;
    bus.l2t_request_tag      = tg;
    bus.l2t_request_set      = st;
    bus.l2t_is_l2_fill       = fill;
    bus.l2t_fill_way         = fw;
    bus.l2t_data_from_memory = {48'h0, tg};
    for (int w = 0; w < NW; w++) begin
      if (use_store) begin
        bus.l2t_valid[w] = sv[st[2:0]][w];
        bus.l2t_tag[w]   = stg[st[2:0]][w];
        bus.l2t_dirty[w] = sd[st[2:0]][w];
      end else begin
        bus.l2t_valid[w] = vm[w];
        bus.l2t_tag[w]   = 16'h0100 + 16'(w);
        bus.l2t_dirty[w] = dm[w];
      end
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v; logic [1:0] op; logic fill; logic [15:0] tg; logic [2:0] fw; logic [7:0] vm; logic [7:0] dm;
    logic [7:0] e_ten; logic e_tval; logic [7:0] e_den; logic e_dval; logic e_lru; logic [2:0] e_lway;
    logic e_hit; logic e_wb; logic [15:0] e_wbtag;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          ehit, ewb;
    logic [2:0]    eway;
    logic [1:0]    rop;
    logic          rfill;
    logic [7:0]    rset;
    logic [TW-1:0] rtag;
    logic [2:0]    rfw;

    bus.l2t_is_restarted_flush = 1'b0;
    bus.l2u_write_en   = 1'b0;
    bus.l2u_write_addr = '0;
    bus.l2u_write_data = '0;

    // Tags in the table phase are 0x100+way, set 7.
    tbl[0]  = '{1'b1, LD,  1'b0, 16'h103, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 16'h0};
    tbl[1]  = '{1'b1, ST,  1'b0, 16'h105, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h20, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 16'h0};
    tbl[2]  = '{1'b1, LD,  1'b0, 16'h105, 3'd0, 8'hDF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0};
    tbl[3]  = '{1'b1, LD,  1'b1, 16'h1FF, 3'd4, 8'hFF, 8'h10, 8'h10, 1'b1, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 16'h104};
    tbl[4]  = '{1'b1, ST,  1'b1, 16'h1FF, 3'd1, 8'hFD, 8'h02, 8'h02, 1'b1, 8'h02, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 16'h0};
    tbl[5]  = '{1'b1, LD,  1'b1, 16'h106, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 16'h0};
    tbl[6]  = '{1'b1, FL,  1'b0, 16'h107, 3'd0, 8'hFF, 8'h80, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 16'h107};
    tbl[7]  = '{1'b1, FL,  1'b0, 16'h102, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 16'h0};
    tbl[8]  = '{1'b1, INV, 1'b0, 16'h100, 3'd0, 8'hFF, 8'h01, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 16'h0};
    tbl[9]  = '{1'b1, FL,  1'b0, 16'h1EE, 3'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0};
    tbl[10] = '{1'b1, INV, 1'b0, 16'h1EE, 3'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0};
    tbl[11] = '{1'b0, LD,  1'b0, 16'h103, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0};
    tbl[12] = '{1'b1, ST,  1'b0, 16'h1EE, 3'd0, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0};

    // Reset held low with a hitting request present
    req(1'b1, LD, 1'b0, 16'h103, 8'd7, 3'd0, 8'hFF, 8'h00);
    chk("rst_lru_en", 64'(bus.l2r_update_lru_en), 64'd0);
    chk("rst_dirty_en", 64'(bus.l2r_update_dirty_en), 64'd0);
    tick();
    chk("rst_req_valid", 64'(bus.l2r_request_valid), 64'd0);
    chk("rst_hit", 64'(bus.l2r_cache_hit), 64'd0);
    chk("rst_data", 64'(bus.l2r_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req(tbl[i].v, tbl[i].op, tbl[i].fill, tbl[i].tg, 8'd7, tbl[i].fw, tbl[i].vm, tbl[i].dm);
      chk($sformatf("v%0d_tag_en", i), 64'(bus.l2r_update_tag_en), 64'(tbl[i].e_ten));
      chk($sformatf("v%0d_dirty_en", i), 64'(bus.l2r_update_dirty_en), 64'(tbl[i].e_den));
      chk($sformatf("v%0d_lru_en", i), 64'(bus.l2r_update_lru_en), 64'(tbl[i].e_lru));
      if (tbl[i].e_ten != 8'h00) chk($sformatf("v%0d_tag_valid", i), 64'(bus.l2r_update_tag_valid), 64'(tbl[i].e_tval));
      if (tbl[i].e_den != 8'h00) chk($sformatf("v%0d_dirty_val", i), 64'(bus.l2r_update_dirty_value), 64'(tbl[i].e_dval));
      if (tbl[i].e_lru) chk($sformatf("v%0d_lru_way", i), 64'(bus.l2r_update_lru_hit_way), 64'(tbl[i].e_lway));
      tick();
      chk($sformatf("v%0d_req_valid", i), 64'(bus.l2r_request_valid), 64'(tbl[i].v));
      chk($sformatf("v%0d_hit", i), 64'(bus.l2r_cache_hit), 64'(tbl[i].e_hit));
      chk($sformatf("v%0d_wb", i), 64'(bus.l2r_needs_writeback), 64'(tbl[i].e_wb));
      if (tbl[i].e_wb) chk($sformatf("v%0d_wb_tag", i), 64'(bus.l2r_writeback_tag), 64'(tbl[i].e_wbtag));
    end

    use_store = 1'b1;
    // Fill set 5 way 2 with tag 0x1A
    req(1'b1, LD, 1'b1, 16'h1A, 8'd5, 3'd2, 8'h0, 8'h0);
    chk("fillA_tag_en", 64'(bus.l2r_update_tag_en), 64'h04);
    chk("fillA_tag_valid", 64'(bus.l2r_update_tag_valid), 64'd1);
    chk("fillA_tag_value", 64'(bus.l2r_update_tag_value), 64'h1A);
    chk("fillA_tag_set", 64'(bus.l2r_update_tag_set), 64'd5);
    chk("fillA_lru_way", 64'(bus.l2r_update_lru_hit_way), 64'd2);
    tick();
    chk("fillA_hit", 64'(bus.l2r_cache_hit), 64'd0);
    chk("fillA_is_fill", 64'(bus.l2r_is_l2_fill), 64'd1);
    chk("fillA_mem_data", 64'(bus.l2r_data_from_memory), 64'h1A);
    bus.l2u_write_en = 1'b1; bus.l2u_write_addr = {3'd2, 8'd5}; bus.l2u_write_data = 64'hAAAA_0000_1111_2222;
    req(1'b0, LD, 1'b0, 16'h0, 8'd0, 3'd0, 8'h0, 8'h0);
    tick();
    bus.l2u_write_en = 1'b0;
    req(1'b1, LD, 1'b0, 16'h1A, 8'd5, 3'd0, 8'h0, 8'h0);
    chk("loadA_tag_en", 64'(bus.l2r_update_tag_en), 64'h00);
    chk("loadA_lru_en", 64'(bus.l2r_update_lru_en), 64'd1);
    chk("loadA_lru_way", 64'(bus.l2r_update_lru_hit_way), 64'd2);
    tick();
    chk("loadA_hit", 64'(bus.l2r_cache_hit), 64'd1);
    chk("loadA_hit_way", 64'(bus.l2r_hit_way), 64'd2);
    chk("loadA_data", bus.l2r_data, 64'hAAAA_0000_1111_2222);
    // Same-address write and read in one cycle returns the new line
    bus.l2u_write_en = 1'b1; bus.l2u_write_data = 64'hBBBB_3333_4444_5555;
    req(1'b1, LD, 1'b0, 16'h1A, 8'd5, 3'd0, 8'h0, 8'h0);
    tick();
    bus.l2u_write_en = 1'b0;
    chk("bypass_data", bus.l2r_data, 64'hBBBB_3333_4444_5555);

    req(1'b1, ST, 1'b0, 16'h1A, 8'd5, 3'd0, 8'h0, 8'h0);
    chk("storeB_dirty_en", 64'(bus.l2r_update_dirty_en), 64'h04);
    chk("storeB_dirty_val", 64'(bus.l2r_update_dirty_value), 64'd1);
    tick();
    req(1'b1, LD, 1'b1, 16'h2B, 8'd5, 3'd2, 8'h0, 8'h0);
    chk("victim_tag_en", 64'(bus.l2r_update_tag_en), 64'h04);
    chk("victim_tag_value", 64'(bus.l2r_update_tag_value), 64'h2B);
    tick();
    chk("victim_wb", 64'(bus.l2r_needs_writeback), 64'd1);
    chk("victim_wb_tag", 64'(bus.l2r_writeback_tag), 64'h1A);
    chk("victim_data", bus.l2r_data, 64'hBBBB_3333_4444_5555);

    // Duplicate fill: tag already resident in way 2, LRU says way 6
    req(1'b1, LD, 1'b1, 16'h2B, 8'd5, 3'd6, 8'h0, 8'h0);
    chk("dup_tag_en", 64'(bus.l2r_update_tag_en), 64'h00);
    chk("dup_lru_way", 64'(bus.l2r_update_lru_hit_way), 64'd2);
    tick();
    chk("dup_wb", 64'(bus.l2r_needs_writeback), 64'd0);
    chk("dup_hit_way", 64'(bus.l2r_hit_way), 64'd2);

    req(1'b1, ST, 1'b0, 16'h2B, 8'd5, 3'd0, 8'h0, 8'h0);
    tick();
    req(1'b1, FL, 1'b0, 16'h2B, 8'd5, 3'd0, 8'h0, 8'h0);
    bus.l2t_is_restarted_flush = 1'b1;
    chk("flush_dirty_en", 64'(bus.l2r_update_dirty_en), 64'h04);
    chk("flush_dirty_val", 64'(bus.l2r_update_dirty_value), 64'd0);
    chk("flush_lru_en", 64'(bus.l2r_update_lru_en), 64'd0);
    tick();
    bus.l2t_is_restarted_flush = 1'b0;
    chk("flush_wb", 64'(bus.l2r_needs_writeback), 64'd1);
    chk("flush_restarted", 64'(bus.l2r_is_restarted_flush), 64'd1);
    req(1'b1, INV, 1'b0, 16'h2B, 8'd5, 3'd0, 8'h0, 8'h0);
    chk("inv_tag_en", 64'(bus.l2r_update_tag_en), 64'h04);
    chk("inv_tag_valid", 64'(bus.l2r_update_tag_valid), 64'd0);
    tick();
    req(1'b1, FL, 1'b0, 16'h2B, 8'd5, 3'd0, 8'h0, 8'h0);
    chk("flmiss_strobes", 64'({bus.l2r_update_tag_en, bus.l2r_update_dirty_en, 7'h0, bus.l2r_update_lru_en}), 64'h0);
    tick();
    chk("flmiss_hit", 64'(bus.l2r_cache_hit), 64'd0);

    // Asynchronous reset in the middle of a request
    req(1'b1, LD, 1'b1, 16'h3C, 8'd6, 3'd3, 8'h0, 8'h0);
    tick();
    chk("pre_rst_valid", 64'(bus.l2r_request_valid), 64'd1);
    req(1'b1, LD, 1'b1, 16'h3D, 8'd7, 3'd1, 8'h0, 8'h0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.l2r_request_valid), 64'd0);
    chk("mid_rst_tag_en", 64'(bus.l2r_update_tag_en), 64'h00);
    chk("mid_rst_dirty_en", 64'(bus.l2r_update_dirty_en), 64'h00);
    chk("mid_rst_lru_en", 64'(bus.l2r_update_lru_en), 64'd0);
    tick();
    chk("mid_rst_no_write", 64'(sv[7][1]), 64'd0);
    chk("pre_rst_written", 64'(sv[6][3]), 64'd1);
    @(negedge clk);
    bus.l2t_request_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("post_rst_valid", 64'(bus.l2r_request_valid), 64'd0);

    // Random back-to-back traffic over sets 0..3
    for (int i = 0; i < 400; i++) begin
      rset  = 8'($urandom_range(0, 3));
      rtag  = 16'h30 + 16'($urandom_range(0, 3));
      rfill = 1'($urandom_range(0, 1));
      rop   = rfill ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      rfw   = 3'($urandom_range(0, 7));
      req(1'b1, rop, rfill, rtag, rset, rfw, 8'h0, 8'h0);
      ehit = 1'b0; eway = '0; ewb = 1'b0;
      for (int w = 0; w < NW; w++)
        if (sv[rset[2:0]][w] && stg[rset[2:0]][w] == rtag) begin
          ehit = 1'b1; eway = 3'(w);
        end
      if (rfill && !ehit) ewb = sv[rset[2:0]][rfw] & sd[rset[2:0]][rfw];
      else if (rop == FL && ehit) ewb = sd[rset[2:0]][eway];
      tick();
      chk("rnd_hit", 64'(bus.l2r_cache_hit), 64'(ehit));
      chk("rnd_wb", 64'(bus.l2r_needs_writeback), 64'(ewb));
      if (ehit) chk("rnd_way", 64'(bus.l2r_hit_way), 64'(eway));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
